// File: rtl/raisin64_pkg.sv
// Shared register-file constants and helpers for the
// raisin64 operand-fetch slice.
package raisin64_pkg;

  localparam int REG_N_W  = 6;
  localparam int NUM_REGS = 64;
  localparam int XLEN     = 64;

  typedef logic [REG_N_W-1:0] reg_n_t;

  localparam reg_n_t REG_ZERO = 6'd0;

  function automatic logic wb_hits(
    input logic   en,
    input reg_n_t wrn,
    input reg_n_t r
  );
    return en && (wrn == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural
// register, with three same-cycle hazard lookups.
module reg_scoreboard
  import raisin64_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   set_en,
  input  reg_n_t set_rn,
  input  logic   wb_en,
  input  reg_n_t wb_rn,
  input  reg_n_t q1_rn,
  input  reg_n_t q2_rn,
  input  reg_n_t q3_rn,
  output logic   hz1,
  output logic   hz2,
  output logic   hz3
);

  logic [NUM_REGS-1:0] pending;

  // set is written last so it wins a same-register collision
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wb_en && wb_rn != REG_ZERO)
        pending[wb_rn] <= 1'b0;
      if (set_en && set_rn != REG_ZERO)
        pending[set_rn] <= 1'b1;
    end
  end

  assign hz1 = pending[q1_rn] &&
               !wb_hits(wb_en, wb_rn, q1_rn);
  assign hz2 = pending[q2_rn] &&
               !wb_hits(wb_en, wb_rn, q2_rn);
  assign hz3 = pending[q3_rn] &&
               !wb_hits(wb_en, wb_rn, q3_rn);

endmodule

// File: rtl/operand_fetch.sv
// Operand-read stage: hazard check, regfile read,
// writeback bypass and a valid/ready register to execute.
module operand_fetch
  import raisin64_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int XLEN      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [5:0]           dec_rs1,
  input  logic [5:0]           dec_rs2,
  input  logic [5:0]           dec_rd,
  input  logic                 dec_rd_en,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  output logic [5:0]           rf_r1_rn,
  output logic [5:0]           rf_r2_rn,
  input  logic [XLEN-1:0]      rf_r1_data,
  input  logic [XLEN-1:0]      rf_r2_data,
  input  logic                 wb_en,
  input  logic [5:0]           wb_rn,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_op1,
  output logic [XLEN-1:0]      ex_op2,
  output logic [5:0]           ex_rd,
  output logic                 ex_rd_en,
  output logic [PAYLOAD_W-1:0] ex_payload
);

  typedef struct packed {
    reg_n_t                rs1;
    reg_n_t                rs2;
    reg_n_t                rd;
    logic                  rd_en;
    logic [PAYLOAD_W-1:0]  payload;
  } s1_t;

  s1_t             s1;
  s1_t             dec_op;
  logic            s1_valid;
  logic            byp1;
  logic            byp2;
  logic [XLEN-1:0] byp_data;

  logic hz1, hz2, hz3;
  logic hazard;
  logic s1_adv;
  logic s1_hold;
  logic accept;

  reg_scoreboard u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (accept && dec_rd_en),
    .set_rn (dec_rd),
    .wb_en  (wb_en),
    .wb_rn  (wb_rn),
    .q1_rn  (dec_rs1),
    .q2_rn  (dec_rs2),
    .q3_rn  (dec_rd),
    .hz1    (hz1),
    .hz2    (hz2),
    .hz3    (hz3)
  );

  assign dec_op = '{
    rs1:     dec_rs1,
    rs2:     dec_rs2,
    rd:      dec_rd,
    rd_en:   dec_rd_en,
    payload: dec_payload
  };

  assign hazard  = hz1 || hz2 || (dec_rd_en && hz3);
  assign s1_adv  = !ex_valid || ex_ready;
  assign s1_hold = s1_valid && !s1_adv;
  assign dec_ready = !rst && !hazard && !s1_hold;
  assign accept  = dec_valid && dec_ready;

  assign rf_r1_rn = s1_hold ? s1.rs1 : dec_rs1;
  assign rf_r2_rn = s1_hold ? s1.rs2 : dec_rs2;

  // A held op re-reads the regfile, which by then
  // holds the bypassed value, so the flags drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1         <= '0;
      byp1       <= 1'b0;
      byp2       <= 1'b0;
      byp_data   <= '0;
      ex_valid   <= 1'b0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_rd      <= '0;
      ex_rd_en   <= 1'b0;
      ex_payload <= '0;
    end else begin
      if (!s1_hold)
        s1_valid <= accept;
      unique case (1'b1)
        accept: begin
          s1       <= dec_op;
          byp1     <= wb_hits(wb_en, wb_rn, dec_rs1);
          byp2     <= wb_hits(wb_en, wb_rn, dec_rs2);
          byp_data <= wb_data;
        end
        s1_hold: begin
          byp1 <= 1'b0;
          byp2 <= 1'b0;
        end
        default: ;
      endcase
      if (s1_adv) begin
        ex_valid <= s1_valid;
        if (s1_valid) begin
          ex_op1     <= byp1 ? byp_data : rf_r1_data;
          ex_op2     <= byp2 ? byp_data : rf_r2_data;
          ex_rd      <= s1.rd;
          ex_rd_en   <= s1.rd_en;
          ex_payload <= s1.payload;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small
// registered-read regfile model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rd_en;
  logic [31:0] dec_payload;
  logic [5:0]  rf_r1_rn, rf_r2_rn;
  logic [63:0] rf_r1_data, rf_r2_data;
  logic        wb_en;
  logic [5:0]  wb_rn;
  logic [63:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_op1, ex_op2;
  logic [5:0]  ex_rd;
  logic        ex_rd_en;
  logic [31:0] ex_payload;

  int tests = 0;
  int fails = 0;

  logic [63:0] mem [64];

  operand_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .dec_rd_en   (dec_rd_en),
    .dec_payload (dec_payload),
    .rf_r1_rn    (rf_r1_rn),
    .rf_r2_rn    (rf_r2_rn),
    .rf_r1_data  (rf_r1_data),
    .rf_r2_data  (rf_r2_data),
    .wb_en       (wb_en),
    .wb_rn       (wb_rn),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_op1      (ex_op1),
    .ex_op2      (ex_op2),
    .ex_rd       (ex_rd),
    .ex_rd_en    (ex_rd_en),
    .ex_payload  (ex_payload)
  );

  always #5 clk = ~clk;

  // regfile: read returns the pre-write value of the same edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 0) ? 64'd0 : 64'h100 + 64'(i);
    end else if (wb_en && wb_rn != 6'd0) begin
      mem[wb_rn] <= wb_data;
    end
    rf_r1_data <= mem[rf_r1_rn];
    rf_r2_data <= mem[rf_r2_rn];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic v, input logic [5:0] r1,
                    input logic [5:0] r2, input logic [5:0] rd,
                    input logic rde, input logic [31:0] pl);
    dec_valid   = v;
    dec_rs1     = r1;
    dec_rs2     = r2;
    dec_rd      = rd;
    dec_rd_en   = rde;
    dec_payload = pl;
  endtask

  initial begin
    rst = 1'b1;
    ex_ready = 1'b1;
    wb_en = 1'b0;
    wb_rn = '0;
    wb_data = '0;
    op(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_op1", ex_op1, 64'd0);
    chk("rst_dec_ready", 64'(dec_ready), 64'd0);
    chk("rst_pending", dut.u_sb.pending, 64'd0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 64'(dec_ready), 64'd1);

    // back-to-back independent ops
    for (int c = 0; c < 6; c++) begin
      if (c < 4)
        op(1, 6'(c + 1), 6'(c + 10), 6'd0, 0, 32'h100 + c);
      else
        op(0, 0, 0, 0, 0, 0);
      tick();
      if (c >= 1 && c <= 4) begin
        chk("b2b_valid", 64'(ex_valid), 64'd1);
        chk("b2b_op1", ex_op1, 64'h100 + 64'(c));
        chk("b2b_op2", ex_op2, 64'h100 + 64'(c + 9));
        chk("b2b_pl", 64'(ex_payload), 64'h100 + 64'(c - 1));
      end
      if (c == 5)
        chk("b2b_drain", 64'(ex_valid), 64'd0);
    end

    // RAW stall on r5, released by writeback
    op(1, 1, 2, 5, 1, 32'h5);
    #1;
    chk("raw_issue_rdy", 64'(dec_ready), 64'd1);
    tick();
    chk("raw_pend5", 64'(dut.u_sb.pending[5]), 64'd1);
    op(1, 5, 2, 6, 0, 32'h6);
    #1;
    chk("raw_stall", 64'(dec_ready), 64'd0);
    tick();
    chk("raw_stall2", 64'(dec_ready), 64'd0);
    wb_en = 1'b1;
    wb_rn = 6'd5;
    wb_data = 64'hDEAD;
    #1;
    chk("raw_release", 64'(dec_ready), 64'd1);
    tick();
    wb_en = 1'b0;
    op(0, 0, 0, 0, 0, 0);
    tick();
    chk("raw_valid", 64'(ex_valid), 64'd1);
    chk("raw_op1", ex_op1, 64'hDEAD);
    chk("raw_op2", ex_op2, 64'h102);
    chk("raw_pend_clr", 64'(dut.u_sb.pending[5]), 64'd0);

    // backpressure with a bypassed op held in S1
    op(1, 1, 2, 8, 1, 32'h8);
    tick();
    op(1, 8, 3, 0, 0, 32'h55);
    wb_en = 1'b1;
    wb_rn = 6'd8;
    wb_data = 64'hBEEF;
    #1;
    chk("bp_accept", 64'(dec_ready), 64'd1);
    tick();
    wb_en = 1'b0;
    ex_ready = 1'b0;
    op(1, 4, 3, 0, 0, 32'h66);
    #1;
    chk("bp_block", 64'(dec_ready), 64'd0);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("bp_hold_v", 64'(ex_valid), 64'd1);
      chk("bp_hold_op1", ex_op1, 64'h101);
      chk("bp_hold_rd", 64'(ex_rd), 64'd8);
      chk("bp_hold_rdy", 64'(dec_ready), 64'd0);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_free", 64'(dec_ready), 64'd1);
    tick();
    op(0, 0, 0, 0, 0, 0);
    chk("bp_op1", ex_op1, 64'hBEEF);
    chk("bp_op2", ex_op2, 64'h103);
    chk("bp_pl", 64'(ex_payload), 64'h55);
    tick();
    chk("bp_next_v", 64'(ex_valid), 64'd1);
    chk("bp_next_op1", ex_op1, 64'h104);
    chk("bp_next_pl", 64'(ex_payload), 64'h66);
    tick();
    chk("bp_drain", 64'(ex_valid), 64'd0);

    // r0 never pending, reads as zero
    op(1, 0, 1, 0, 1, 32'h0);
    #1;
    chk("r0_rdy", 64'(dec_ready), 64'd1);
    tick();
    op(0, 0, 0, 0, 0, 0);
    chk("r0_pend", dut.u_sb.pending, 64'd0);
    tick();
    chk("r0_op1", ex_op1, 64'd0);
    chk("r0_rd_en", 64'(ex_rd_en), 64'd1);

    // set/clear collision on r7
    op(1, 1, 2, 7, 1, 32'h7);
    tick();
    chk("col_pend_a", dut.u_sb.pending, 64'h80);
    op(1, 1, 2, 7, 1, 32'h77);
    wb_en = 1'b1;
    wb_rn = 6'd7;
    wb_data = 64'h77;
    #1;
    chk("col_rdy", 64'(dec_ready), 64'd1);
    tick();
    wb_en = 1'b0;
    chk("col_pend_b", dut.u_sb.pending, 64'h80);

    // reset with ops in S1 and EX
    op(1, 1, 2, 9, 1, 32'hAA);
    tick();
    op(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mrst_rdy", 64'(dec_ready), 64'd0);
    tick();
    chk("mrst_valid", 64'(ex_valid), 64'd0);
    chk("mrst_pend", dut.u_sb.pending, 64'd0);
    chk("mrst_pl", 64'(ex_payload), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("mrst_lost", 64'(ex_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
